// File: rtl/display_wr_sched_pkg.sv
// Shared types and constants for the display memory write-port scheduler.
package display_wr_sched_pkg;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 8;
  localparam int NUM_REQ_MAX = 8;

  typedef logic [ADDR_W-1:0] disp_addr_t;
  typedef logic [DATA_W-1:0] disp_data_t;

  // Scheduler states, kept as plain encoded constants so older code can compare against them.
  typedef logic [1:0] sched_state_t;
  localparam sched_state_t IDLE     = 2'd0;
  localparam sched_state_t WAIT_EOF = 2'd1;
  localparam sched_state_t CLEAR    = 2'd2;

endpackage

// File: rtl/display_wr_sched_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last winner and wraps.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [LW-1:0] grant_idx,
  output logic          any
);

  logic [LW:0] cand;

  // Walk the candidates last+1 .. last+N (mod N) and take the first asserted request.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = {1'b0, last} + (LW+1)'(k);
      if (cand >= (LW+1)'(N)) begin
        cand = cand - (LW+1)'(N);
      end else begin
        cand = cand;
      end
      if (!any && req[cand[LW-1:0]]) begin
        grant[cand[LW-1:0]] = 1'b1;
        grant_idx           = cand[LW-1:0];
        any                 = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/display_wr_sched.sv
// Display memory write-port scheduler: round-robin requester sharing plus a fill/clear engine.
module display_wr_sched
  import display_wr_sched_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int CLEAR_ON_EOF = 1
) (
  input  logic                     clk,
  input  logic                     reset_ni,
  input  logic                     eof_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  disp_addr_t [NUM_REQ-1:0] req_addr_i,
  input  disp_data_t [NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic                     clear_start_i,
  input  disp_data_t               clear_fill_i,
  input  disp_addr_t               clear_len_i,
  output logic                     clear_busy_o,
  output logic                     display_wr_en_o,
  output disp_addr_t               display_wr_addr_o,
  output disp_data_t               display_wr_data_o
);

  localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [LW-1:0] LAST_RESET = LW'(NUM_REQ - 1);

  sched_state_t  state, state_n;
  logic [LW-1:0] last_grant, last_grant_n;
  disp_data_t    fill, fill_n;
  disp_addr_t    len, len_n;
  disp_addr_t    clr_cnt, clr_cnt_n;
  logic          busy, busy_n;
  logic          wr_en, wr_en_n;
  disp_addr_t    wr_addr, wr_addr_n;
  disp_data_t    wr_data, wr_data_n;
  logic [NUM_REQ-1:0] ready;

  logic [NUM_REQ-1:0] arb_grant;
  logic [LW-1:0]      arb_idx;
  logic               arb_any;

  rr_arbiter #(
    .N  (NUM_REQ),
    .LW (LW)
  ) u_arb (
    .req       (req_valid_i),
    .last      (last_grant),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  // Next-state logic: requesters only see a grant in IDLE when no clear is starting.
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    fill_n       = fill;
    len_n        = len;
    clr_cnt_n    = clr_cnt;
    wr_en_n      = 1'b0;
    wr_addr_n    = wr_addr;
    wr_data_n    = wr_data;
    ready        = '0;
    case (state)
      IDLE: begin
        if (clear_start_i) begin
          fill_n    = clear_fill_i;
          len_n     = clear_len_i;
          clr_cnt_n = '0;
          if (CLEAR_ON_EOF != 0) begin
            state_n = WAIT_EOF;
          end else begin
            state_n = CLEAR;
          end
        end else begin
          ready = arb_grant;
          if (arb_any) begin
            wr_en_n      = 1'b1;
            wr_addr_n    = req_addr_i[arb_idx];
            wr_data_n    = req_data_i[arb_idx];
            last_grant_n = arb_idx;
          end else begin
            wr_en_n = 1'b0;
          end
        end
      end
      WAIT_EOF: begin
        if (eof_i) begin
          state_n = CLEAR;
        end else begin
          state_n = WAIT_EOF;
        end
      end
      CLEAR: begin
        if (len == '0) begin
          // Zero-length clear: spend one cycle here, write nothing.
          state_n = IDLE;
        end else begin
          wr_en_n   = 1'b1;
          wr_addr_n = clr_cnt;
          wr_data_n = fill;
          if (clr_cnt == len - disp_addr_t'(1)) begin
            state_n = IDLE;
          end else begin
            clr_cnt_n = clr_cnt + disp_addr_t'(1);
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // State, clear context and registered write port.
  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      state      <= IDLE;
      last_grant <= LAST_RESET;
      fill       <= '0;
      len        <= '0;
      clr_cnt    <= '0;
      busy       <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      fill       <= fill_n;
      len        <= len_n;
      clr_cnt    <= clr_cnt_n;
      busy       <= busy_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
    end
  end

  assign req_ready_o       = ready;
  assign clear_busy_o      = busy;
  assign display_wr_en_o   = wr_en;
  assign display_wr_addr_o = wr_addr;
  assign display_wr_data_o = wr_data;

endmodule

// File: tb/tb_display_wr_sched.sv
// Directed bench for display_wr_sched: one instance clears on EOF, one clears immediately.
module tb_display_wr_sched;
  import display_wr_sched_pkg::*;

  logic             clk;
  logic             reset_ni;
  logic             eof;
  logic [1:0]       req_valid;
  disp_addr_t [1:0] req_addr;
  disp_data_t [1:0] req_data;
  logic             clear_start;
  disp_data_t       clear_fill;
  disp_addr_t       clear_len;

  logic [1:0] ready1, ready0;
  logic       busy1, busy0, wen1, wen0;
  disp_addr_t waddr1, waddr0;
  disp_data_t wdata1, wdata0;

  int n_checks = 0;
  int n_fail   = 0;
  int busy_cnt;

  display_wr_sched #(.NUM_REQ(2), .CLEAR_ON_EOF(1)) dut_eof (
    .clk               (clk),
    .reset_ni          (reset_ni),
    .eof_i             (eof),
    .req_valid_i       (req_valid),
    .req_addr_i        (req_addr),
    .req_data_i        (req_data),
    .req_ready_o       (ready1),
    .clear_start_i     (clear_start),
    .clear_fill_i      (clear_fill),
    .clear_len_i       (clear_len),
    .clear_busy_o      (busy1),
    .display_wr_en_o   (wen1),
    .display_wr_addr_o (waddr1),
    .display_wr_data_o (wdata1)
  );

  display_wr_sched #(.NUM_REQ(2), .CLEAR_ON_EOF(0)) dut_imm (
    .clk               (clk),
    .reset_ni          (reset_ni),
    .eof_i             (eof),
    .req_valid_i       (req_valid),
    .req_addr_i        (req_addr),
    .req_data_i        (req_data),
    .req_ready_o       (ready0),
    .clear_start_i     (clear_start),
    .clear_fill_i      (clear_fill),
    .clear_len_i       (clear_len),
    .clear_busy_o      (busy0),
    .display_wr_en_o   (wen0),
    .display_wr_addr_o (waddr0),
    .display_wr_data_o (wdata0)
  );

  // Free-running clock, posedge at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    eof         = 1'b0;
    req_valid   = 2'b00;
    req_addr[0] = 12'h000;
    req_addr[1] = 12'h000;
    req_data[0] = 8'h00;
    req_data[1] = 8'h00;
    clear_start = 1'b0;
    clear_fill  = 8'h00;
    clear_len   = 12'h000;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_ni = 1'b0;
    tick();
    reset_ni = 1'b1;
  endtask

  initial begin
    idle_inputs();
    reset_ni = 1'b0;
    #1;
    // Reset values
    check_eq("rst_wen",   32'(wen1),   32'h0);
    check_eq("rst_addr",  32'(waddr1), 32'h0);
    check_eq("rst_data",  32'(wdata1), 32'h0);
    check_eq("rst_busy",  32'(busy1),  32'h0);
    check_eq("rst_ready", 32'(ready1), 32'h0);
    tick();
    tick();
    reset_ni = 1'b1;

    // Test 1: both requesters held valid, alternate grants 0,1,0,1
    req_valid   = 2'b11;
    req_addr[0] = 12'h010;
    req_addr[1] = 12'h020;
    req_data[0] = 8'hA0;
    req_data[1] = 8'hB0;
    #1;
    for (int i = 0; i < 4; i++) begin
      check_eq("rr_ready", 32'(ready1), (i % 2 == 0) ? 32'h1 : 32'h2);
      tick();
      check_eq("rr_wen",  32'(wen1),   32'h1);
      check_eq("rr_addr", 32'(waddr1), (i % 2 == 0) ? 32'h010 : 32'h020);
      check_eq("rr_data", 32'(wdata1), (i % 2 == 0) ? 32'hA0 : 32'hB0);
    end
    req_valid = 2'b00;
    #1;
    check_eq("rr_ready_off", 32'(ready1), 32'h0);
    tick();
    check_eq("rr_idle_wen",  32'(wen1),   32'h0);
    check_eq("rr_idle_addr", 32'(waddr1), 32'h020);

    // Test 2: only requester 1 valid
    req_valid   = 2'b10;
    req_addr[1] = 12'h005;
    req_data[1] = 8'h41;
    #1;
    check_eq("r1_ready", 32'(ready1), 32'h2);
    tick();
    req_valid = 2'b00;
    check_eq("r1_wen",  32'(wen1),   32'h1);
    check_eq("r1_addr", 32'(waddr1), 32'h005);
    check_eq("r1_data", 32'(wdata1), 32'h41);
    tick();
    check_eq("r1_wen_off", 32'(wen1), 32'h0);

    // Test 3: clear on EOF, fill 0x20 len 4, EOF sampled 11 edges after start
    do_reset();
    clear_start = 1'b1;
    clear_fill  = 8'h20;
    clear_len   = 12'd4;
    req_valid   = 2'b01;
    req_addr[0] = 12'h033;
    req_data[0] = 8'h5A;
    #1;
    check_eq("clr_start_ready", 32'(ready1), 32'h0);
    busy_cnt = 0;
    tick();
    clear_start = 1'b0;
    if (busy1) busy_cnt++;
    check_eq("clr_busy_rise", 32'(busy1), 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy1) busy_cnt++;
      check_eq("clr_wait_ready", 32'(ready1), 32'h0);
      check_eq("clr_wait_wen",   32'(wen1),   32'h0);
    end
    eof = 1'b1;
    tick();
    eof = 1'b0;
    if (busy1) busy_cnt++;
    check_eq("clr_entry_wen", 32'(wen1), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      if (busy1) busy_cnt++;
      check_eq("clr_wen",   32'(wen1),   32'h1);
      check_eq("clr_addr",  32'(waddr1), 32'(k));
      check_eq("clr_data",  32'(wdata1), 32'h20);
      check_eq("clr_busy",  32'(busy1),  (k < 3) ? 32'h1 : 32'h0);
      check_eq("clr_ready", 32'(ready1), (k < 3) ? 32'h0 : 32'h1);
    end
    check_eq("clr_busy_cycles", 32'(busy_cnt), 32'd15);
    tick();
    req_valid = 2'b00;
    check_eq("clr_after_addr", 32'(waddr1), 32'h033);
    check_eq("clr_after_data", 32'(wdata1), 32'h5A);

    // Test 4: immediate clear, len 3, with req0 valid at the same time
    do_reset();
    clear_start = 1'b1;
    clear_fill  = 8'h55;
    clear_len   = 12'd3;
    req_valid   = 2'b01;
    req_addr[0] = 12'h044;
    req_data[0] = 8'h99;
    #1;
    check_eq("imm_start_ready", 32'(ready0), 32'h0);
    tick();
    clear_start = 1'b0;
    check_eq("imm_busy", 32'(busy0), 32'h1);
    check_eq("imm_wen0", 32'(wen0),  32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("imm_wen",   32'(wen0),   32'h1);
      check_eq("imm_addr",  32'(waddr0), 32'(k));
      check_eq("imm_data",  32'(wdata0), 32'h55);
      check_eq("imm_busyk", 32'(busy0),  (k < 2) ? 32'h1 : 32'h0);
      check_eq("imm_ready", 32'(ready0), (k < 2) ? 32'h0 : 32'h1);
    end
    tick();
    req_valid = 2'b00;
    check_eq("imm_req_wen",  32'(wen0),   32'h1);
    check_eq("imm_req_addr", 32'(waddr0), 32'h044);
    check_eq("imm_req_data", 32'(wdata0), 32'h99);
    tick();
    check_eq("imm_idle_wen", 32'(wen0), 32'h0);

    // Test 5: zero-length clear on EOF
    do_reset();
    clear_start = 1'b1;
    clear_len   = 12'd0;
    tick();
    clear_start = 1'b0;
    check_eq("z_busy_wait", 32'(busy1), 32'h1);
    eof = 1'b1;
    tick();
    eof = 1'b0;
    check_eq("z_busy_clear", 32'(busy1), 32'h1);
    check_eq("z_wen_clear",  32'(wen1),  32'h0);
    tick();
    check_eq("z_busy_done", 32'(busy1), 32'h0);
    check_eq("z_wen_done",  32'(wen1),  32'h0);

    // Test 6: reset during the second clear write
    do_reset();
    clear_start = 1'b1;
    clear_fill  = 8'h7E;
    clear_len   = 12'd4;
    tick();
    clear_start = 1'b0;
    eof = 1'b1;
    tick();
    eof = 1'b0;
    tick();
    check_eq("mr_w0_addr", 32'(waddr1), 32'h0);
    tick();
    check_eq("mr_w1_wen",  32'(wen1),   32'h1);
    check_eq("mr_w1_addr", 32'(waddr1), 32'h1);
    reset_ni = 1'b0;
    #1;
    check_eq("mr_async_wen",  32'(wen1),   32'h0);
    check_eq("mr_async_busy", 32'(busy1),  32'h0);
    check_eq("mr_async_addr", 32'(waddr1), 32'h0);
    tick();
    reset_ni    = 1'b1;
    req_valid   = 2'b11;
    req_addr[0] = 12'h061;
    req_addr[1] = 12'h062;
    req_data[0] = 8'h11;
    req_data[1] = 8'h22;
    #1;
    check_eq("mr_post_ready", 32'(ready1), 32'h1);
    check_eq("mr_post_busy",  32'(busy1),  32'h0);
    check_eq("mr_post_wen",   32'(wen1),   32'h0);
    tick();
    req_valid = 2'b00;
    check_eq("mr_first_wen",  32'(wen1),   32'h1);
    check_eq("mr_first_addr", 32'(waddr1), 32'h061);
    check_eq("mr_first_data", 32'(wdata1), 32'h11);
    tick();
    check_eq("mr_idle_wen", 32'(wen1), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/display_wr_sched.md
# display_wr_sched

Write-port scheduler for the display memory inside the video subsystem. Shares the single `display_wr_*` port of `video_main` among `NUM_REQ` requesters (demo writer, text console, etc.) with round-robin arbitration. It also contains a hardware clear engine that fills a region of display memory with one word, either immediately or starting at the next end-of-frame. All outputs are registered and drive `video_main` directly.

## Interface

Parameters:
- `NUM_REQ`, default 2: number of requesters, 1..8.
- `CLEAR_ON_EOF`, default 1: 1 means the clear engine waits for `eof_i` before writing; 0 means it starts immediately.

Ports:
- `clk`  in  1: design clock (PLL output).
- `reset_ni`  in  1: asynchronous, active-low reset.
- `eof_i`  in  1: one-cycle end-of-frame pulse from `video_main`.
- `req_valid_i`  in  `NUM_REQ`: per-requester write request.
- `req_addr_i`  in  `NUM_REQ` x `disp_addr_t`: per-requester write address.
- `req_data_i`  in  `NUM_REQ` x `disp_data_t`: per-requester write data.
- `req_ready_o`  out  `NUM_REQ`: combinational grant, one-hot or zero.
- `clear_start_i`  in  1: one-cycle pulse that starts a clear.
- `clear_fill_i`  in  `disp_data_t`: fill word, captured at start.
- `clear_len_i`  in  `disp_addr_t`: number of words to write from address 0, captured at start.
- `clear_busy_o`  out  1: clear pending or in progress.
- `display_wr_en_o`  out  1: registered write enable to `video_main`.
- `display_wr_addr_o`  out  `disp_addr_t`: registered write address.
- `display_wr_data_o`  out  `disp_data_t`: registered write data.

## Operation

- States: IDLE, WAIT_EOF, CLEAR. Reset state is IDLE.
- IDLE:
  - Round-robin arbitration among asserted `req_valid_i`. The search starts at index `last_grant+1` and wraps modulo `NUM_REQ`.
  - `req_ready_o[i]` is 1 only for the winner. A transfer occurs when `valid & ready`. `last_grant` updates on each transfer.
- Simultaneous `clear_start_i` in IDLE has priority: all `req_ready_o` are 0 that cycle.
- On `clear_start_i` in IDLE:
  - Capture fill and length.
  - Set `clr_cnt` = 0.
  - Go to WAIT_EOF if `CLEAR_ON_EOF`, otherwise go to CLEAR.
- WAIT_EOF: `req_ready_o` stays 0. When `eof_i` = 1, go to CLEAR.
- CLEAR:
  - Each cycle, register a write of fill data at `clr_cnt` and increment `clr_cnt`.
  - When `clr_cnt == len-1`, register that final write and go to IDLE.
  - If `len == 0`, go to IDLE after one CLEAR cycle with no write.
  - `req_ready_o` stays 0.
- `clear_start_i` outside IDLE is ignored (no queueing).
- `eof_i` outside WAIT_EOF is ignored.
- Requesters must not make `req_valid_i` depend on `req_ready_o`. A requester must hold `req_valid_i`, `req_addr_i` and `req_data_i` stable until its transfer occurs.
- `clr_cnt` has width `disp_addr_t`. `len` is never exceeded, so the counter never wraps.

## Timing

- Reset values:
  - `display_wr_en_o` = 0, `display_wr_addr_o` = 0, `display_wr_data_o` = 0.
  - `clear_busy_o` = 0, `req_ready_o` = 0.
  - State = IDLE; `last_grant` = `NUM_REQ-1`, so index 0 wins first after reset.
- Request latency: transfer at edge N, then `display_wr_en_o` = 1 with that address and data during cycle N..N+1. Sustained throughput is 1 write per cycle.
- Idle cycle: `display_wr_en_o` = 0; address and data hold their last values.
- Clear timing:
  - `clear_start_i` sampled at edge N, so `clear_busy_o` = 1 from edge N.
  - Entry into CLEAR at edge E: E = N if `CLEAR_ON_EOF` = 0, otherwise E = the edge sampling `eof_i`.
  - Writes for addresses 0..len-1 appear on consecutive cycles starting at edge E+1.
  - `clear_busy_o` falls at the same edge the last write appears.
- Reset asserted mid-clear or mid-transfer: all outputs go to their reset values immediately. No partial write is presented after release.

## Structure

- Shared package: `disp_addr_t` and `disp_data_t` already exist. Add `sched_state_t` (IDLE/WAIT_EOF/CLEAR) and `NUM_REQ_MAX = 8`.
- Sub-module `rr_arbiter`:
  - Parameter: `N`.
  - Inputs: `req[N]`, `last[$clog2(N)]`.
  - Outputs: one-hot `grant`, `grant_idx`, `any`.
  - Purely combinational. The `last_grant` register stays in the scheduler.

## Test plan

- Reset release, then req0 and req1 held valid (addresses 0x10 and 0x20) → grant order 0,1,0,1. Writes appear 1 cycle after each transfer; 4 writes in 4 cycles.
- Only req1 valid, address 0x05, data 0x41 → `req_ready_o` = 2'b10 the same cycle. Next cycle: `display_wr_en_o` = 1, address 0x05, data 0x41; the cycle after: `display_wr_en_o` = 0.
- `CLEAR_ON_EOF` = 1, `clear_start_i` with fill 0x20 and len 4, `eof_i` 10 cycles later → `clear_busy_o` high for 11 + 4 cycles. Writes to addresses 0..3 with data 0x20. No grants while busy despite req0 valid.
- `CLEAR_ON_EOF` = 0, `clear_start_i` and req0 valid in the same cycle → req0 not granted that cycle; 3 clear writes (len 3) appear first; req0 is granted the cycle after busy falls.
- `clear_len_i` = 0 → `clear_busy_o` pulses for exactly 1 cycle after CLEAR entry; no writes.
- `reset_ni` low for 1 cycle during the 2nd clear write → `display_wr_en_o` and `clear_busy_o` go to 0 asynchronously. After release: state IDLE, and req0 wins first.
